// File: rtl/noc_flit_rx_decode.sv
// Router input stage: per-VC flit FIFOs, round-robin VC arbitration, header
// decode with XY routing into a registered valid/ready slot, credit return.
module noc_flit_rx_decode #(
  parameter int unsigned FLIT_LEN   = 256,
  parameter int unsigned VC_ID_W    = 3,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [1:0]  CUR_X      = 2'd0,
  parameter logic [1:0]  CUR_Y      = 2'd0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_vld,
  input  logic [VC_ID_W-1:0]  in_vc,
  input  logic [FLIT_LEN-1:0] in_flit,
  output logic                credit_vld,
  output logic [VC_ID_W-1:0]  credit_vc,
  output logic                out_vld,
  input  logic                out_rdy,
  output logic [VC_ID_W-1:0]  out_vc,
  output logic [FLIT_LEN-1:0] out_flit,
  output logic [6:0]          out_tgt_id,
  output logic [6:0]          out_src_id,
  output logic [11:0]         out_txn_id,
  output logic [3:0]          out_qos,
  output logic [2:0]          out_route,
  output logic                ovf_err
);

  localparam int unsigned VC_NUM = 1 << VC_ID_W;
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  localparam logic [2:0] ROUTE_LOCAL = 3'd0;
  localparam logic [2:0] ROUTE_EAST  = 3'd1;
  localparam logic [2:0] ROUTE_WEST  = 3'd2;
  localparam logic [2:0] ROUTE_NORTH = 3'd3;
  localparam logic [2:0] ROUTE_SOUTH = 3'd4;

  logic [VC_NUM-1:0]   req;
  logic [VC_NUM-1:0]   full_v;
  logic [VC_NUM-1:0]   enq_v;
  logic [VC_NUM-1:0]   deq_v;
  logic [FLIT_LEN-1:0] heads [VC_NUM];

  logic                slot_free;
  logic                found;
  logic                grant;
  logic [VC_ID_W-1:0]  gnt_vc;
  logic [VC_ID_W-1:0]  idx;
  logic [VC_ID_W-1:0]  rr;
  logic [FLIT_LEN-1:0] head_flit;

  // X is resolved before Y; unsigned 2-bit compares against this router.
  function automatic logic [2:0] xy_route(input logic [1:0] x, input logic [1:0] y);
    if (x > CUR_X)      return ROUTE_EAST;
    else if (x < CUR_X) return ROUTE_WEST;
    else if (y > CUR_Y) return ROUTE_NORTH;
    else if (y < CUR_Y) return ROUTE_SOUTH;
    else                return ROUTE_LOCAL;
  endfunction

  for (genvar v = 0; v < VC_NUM; v++) begin : g_vc
    logic [FLIT_LEN-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [CNT_W-1:0]    count;

    assign req[v]    = (count != '0);
    assign full_v[v] = (count == FULL_CNT);
    assign enq_v[v]  = in_vld && (in_vc == VC_ID_W'(v)) && !full_v[v];
    assign deq_v[v]  = grant && (gnt_vc == VC_ID_W'(v));
    assign heads[v]  = mem[rd_ptr];

    always_ff @(posedge clk) begin
      if (rst) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (enq_v[v]) wr_ptr <= wr_ptr + 1'b1;
        if (deq_v[v]) rd_ptr <= rd_ptr + 1'b1;
        if (enq_v[v] && !deq_v[v])      count <= count + 1'b1;
        else if (!enq_v[v] && deq_v[v]) count <= count - 1'b1;
      end
    end

    // Payload storage needs no reset; occupancy is tracked by count.
    always_ff @(posedge clk) begin
      if (enq_v[v]) mem[wr_ptr] <= in_flit;
    end
  end

  // Round-robin search starting at rr; a grant needs a free output slot.
  always_comb begin
    slot_free = !out_vld || out_rdy;
    found     = 1'b0;
    gnt_vc    = rr;
    idx       = rr;
    for (int unsigned i = 0; i < VC_NUM; i++) begin
      idx = rr + VC_ID_W'(i);
      if (!found && req[idx]) begin
        found  = 1'b1;
        gnt_vc = idx;
      end
    end
    grant = found && slot_free;
  end

  assign head_flit = heads[gnt_vc];

  always_ff @(posedge clk) begin
    if (rst) begin
      rr         <= '0;
      out_vld    <= 1'b0;
      credit_vld <= 1'b0;
      credit_vc  <= '0;
      ovf_err    <= 1'b0;
      out_vc     <= '0;
      out_flit   <= '0;
      out_tgt_id <= '0;
      out_src_id <= '0;
      out_txn_id <= '0;
      out_qos    <= '0;
      out_route  <= '0;
    end else begin
      credit_vld <= grant;
      if (in_vld && full_v[in_vc]) ovf_err <= 1'b1;
      if (grant) begin
        rr         <= gnt_vc + 1'b1;
        credit_vc  <= gnt_vc;
        out_vld    <= 1'b1;
        out_vc     <= gnt_vc;
        out_flit   <= head_flit;
        out_tgt_id <= head_flit[6:0];
        out_src_id <= head_flit[13:7];
        out_txn_id <= head_flit[25:14];
        out_qos    <= head_flit[29:26];
        out_route  <= xy_route(head_flit[1:0], head_flit[3:2]);
      end else if (out_rdy) begin
        out_vld <= 1'b0;
      end
    end
  end

endmodule
